// File: rtl/game_state_fsm.sv
// Match sequencer for the two-player light-cycle game: title, countdown, play,
// pause after a crash, match over. Crash levels become single point pulses.
module game_state_fsm #(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int PAUSE_FRAMES     = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       blue_crashed,
  input  logic       red_crashed,
  input  logic       Blue_W,
  input  logic       Red_W,
  output logic [2:0] Game_State,
  output logic       reset_round,
  output logic       point_blue,
  output logic       point_red,
  output logic       round_active,
  output logic [7:0] frames_left,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    TITLE      = 3'd0,
    MATCH_INIT = 3'd1,
    COUNTDOWN  = 3'd2,
    PLAYING    = 3'd3,
    ROUND_OVER = 3'd4,
    MATCH_OVER = 3'd5
  } state_t;

  localparam logic [7:0] CD_LOAD    = 8'(COUNTDOWN_FRAMES);
  localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_FRAMES);

  state_t     state;
  logic [7:0] counter;
  logic [2:0] frame_sync;
  logic [2:0] start_sync;
  logic       frame_tick;
  logic       start_edge;

  // Two synchronizer flops, then a third flop holding the previous level for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync <= 3'b000;
      start_sync <= 3'b000;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_clk};
      start_sync <= {start_sync[1:0], start_key};
    end
  end

  assign frame_tick = frame_sync[1] & ~frame_sync[2];
  assign start_edge = start_sync[1] & ~start_sync[2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= TITLE;
      counter      <= 8'd0;
      reset_round  <= 1'b0;
      point_blue   <= 1'b0;
      point_red    <= 1'b0;
      round_active <= 1'b0;
      winner       <= 2'b00;
    end else begin
      reset_round <= 1'b0;
      point_blue  <= 1'b0;
      point_red   <= 1'b0;
      case (state)
        TITLE: begin
          if (start_edge) begin
            state       <= MATCH_INIT;
            reset_round <= 1'b1;
            winner      <= 2'b00;
          end
        end
        MATCH_INIT: begin
          state   <= COUNTDOWN;
          counter <= CD_LOAD;
        end
        COUNTDOWN: begin
          if (frame_tick) begin
            if (counter <= 8'd1) begin
              counter      <= 8'd0;
              state        <= PLAYING;
              round_active <= 1'b1;
            end else begin
              counter <= counter - 8'd1;
            end
          end
        end
        PLAYING: begin
          // A crash wins over a coincident frame tick; a draw credits nobody.
          if (blue_crashed || red_crashed) begin
            state        <= ROUND_OVER;
            counter      <= PAUSE_LOAD;
            round_active <= 1'b0;
            point_blue   <= red_crashed & ~blue_crashed;
            point_red    <= blue_crashed & ~red_crashed;
          end
        end
        ROUND_OVER: begin
          if (frame_tick) begin
            if (counter <= 8'd1) begin
              counter <= 8'd0;
              if (Blue_W) begin
                state  <= MATCH_OVER;
                winner <= 2'b01;
              end else if (Red_W) begin
                state  <= MATCH_OVER;
                winner <= 2'b10;
              end else begin
                state       <= COUNTDOWN;
                counter     <= CD_LOAD;
                reset_round <= 1'b1;
              end
            end else begin
              counter <= counter - 8'd1;
            end
          end
        end
        MATCH_OVER: begin
          if (start_edge) begin
            state       <= MATCH_INIT;
            reset_round <= 1'b1;
            winner      <= 2'b00;
          end
        end
        default: begin
          state        <= TITLE;
          counter      <= 8'd0;
          round_active <= 1'b0;
          winner       <= 2'b00;
        end
      endcase
    end
  end

  assign Game_State  = state;
  assign frames_left = counter;

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed bench for game_state_fsm: hand sequences for reset and held start,
// then a table of stimulus steps with expected state and pulse counts.
module tb_game_state_fsm;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       start_key;
  logic       blue_crashed;
  logic       red_crashed;
  logic       Blue_W;
  logic       Red_W;
  logic [2:0] Game_State;
  logic       reset_round;
  logic       point_blue;
  logic       point_red;
  logic       round_active;
  logic [7:0] frames_left;
  logic [1:0] winner;

  game_state_fsm #(.COUNTDOWN_FRAMES(3), .PAUSE_FRAMES(2)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .blue_crashed(blue_crashed), .red_crashed(red_crashed),
    .Blue_W(Blue_W), .Red_W(Red_W), .Game_State(Game_State),
    .reset_round(reset_round), .point_blue(point_blue), .point_red(point_red),
    .round_active(round_active), .frames_left(frames_left), .winner(winner)
  );

  typedef struct {
    bit         start, frame, blue, red, bw, rw;
    logic [2:0] st;
    logic [7:0] fl;
    bit         act;
    logic [1:0] win;
    int         pb, pr, rr, mi;
  } vec_t;

  vec_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  int n_pb = 0, n_pr = 0, n_rr = 0, n_mi = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Count high cycles of each pulse output, sampled mid-cycle.
  always @(negedge Clk) begin
    if (point_blue)         n_pb++;
    if (point_red)          n_pr++;
    if (reset_round)        n_rr++;
    if (Game_State == 3'd1) n_mi++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %0d, expected %0d", idx, nm, act, exp);
    end
  endtask

  task automatic add(input bit start, frame, blue, red, bw, rw,
                     input int st, fl, act, win, pb, pr, rr, mi);
    vec_t v;
    v.start = start; v.frame = frame; v.blue = blue; v.red = red;
    v.bw = bw; v.rw = rw;
    v.st = 3'(st); v.fl = 8'(fl); v.act = act[0]; v.win = 2'(win);
    v.pb = pb; v.pr = pr; v.rr = rr; v.mi = mi;
    q.push_back(v);
  endtask

  // Three frame ticks from a fresh countdown into PLAYING.
  task automatic cd_rows();
    add(0,1,0,0,0,0, 2,2,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 2,1,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 3,0,1,0, 0,0,0,0);
  endtask

  initial begin
    int s_pb, s_pr, s_rr, s_mi;
    Reset = 1'b1; frame_clk = 0; start_key = 0;
    blue_crashed = 0; red_crashed = 0; Blue_W = 0; Red_W = 0;
    step(3);
    check("reset_state", -1, Game_State, 0);
    check("reset_outputs", -1, {reset_round, point_blue, point_red, round_active, frames_left, winner}, 0);
    Reset = 1'b0;
    step(2);

    // Held start key: exactly one MATCH_INIT cycle.
    s_mi = n_mi; s_rr = n_rr;
    start_key = 1'b1;
    step(100);
    $display("held start: state=%0d frames_left=%0d", Game_State, frames_left);
    check("held_start_state", -2, Game_State, 2);
    check("held_start_frames", -2, frames_left, 3);
    check("held_start_init_cycles", -2, n_mi - s_mi, 1);
    check("held_start_reset_round", -2, n_rr - s_rr, 1);
    start_key = 1'b0;
    step(4);

    // Asynchronous reset between edges mid-countdown.
    @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    $display("async reset: state=%0d frames_left=%0d", Game_State, frames_left);
    check("async_reset_state", -3, Game_State, 0);
    check("async_reset_outputs", -3, {reset_round, point_blue, point_red, round_active, frames_left, winner}, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    step(20);
    check("title_after_reset", -3, Game_State, 0);

    // start frame blue red bw rw | state frames act win | pb pr rr mi
    add(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0,0, 2,3,0,0, 0,0,1,1);
    add(0,1,0,0,0,0, 2,2,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 2,1,0,0, 0,0,0,0);
    add(1,0,0,0,0,0, 2,1,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 3,0,1,0, 0,0,0,0);
    add(1,0,0,0,0,0, 3,0,1,0, 0,0,0,0);
    add(0,0,0,1,0,0, 4,2,0,0, 1,0,0,0);
    add(0,1,0,1,0,0, 4,1,0,0, 0,0,0,0);
    add(0,1,0,1,0,0, 2,3,0,0, 0,0,1,0);
    cd_rows();
    add(0,0,1,1,0,0, 4,2,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 4,1,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 2,3,0,0, 0,0,1,0);
    cd_rows();
    add(0,0,1,0,0,0, 4,2,0,0, 0,1,0,0);
    add(0,1,0,0,1,0, 4,1,0,0, 0,0,0,0);
    add(0,1,0,0,1,0, 5,0,0,1, 0,0,0,0);
    add(0,1,0,0,1,0, 5,0,0,1, 0,0,0,0);
    add(1,0,0,0,0,0, 2,3,0,0, 0,0,1,1);
    cd_rows();
    add(0,0,0,1,0,0, 4,2,0,0, 1,0,0,0);
    add(0,1,0,0,0,1, 4,1,0,0, 0,0,0,0);
    add(0,1,0,0,0,1, 5,0,0,2, 0,0,0,0);
    add(1,0,0,0,0,0, 2,3,0,0, 0,0,1,1);
    cd_rows();
    add(0,0,1,0,0,0, 4,2,0,0, 0,1,0,0);
    add(0,1,0,0,1,1, 4,1,0,0, 0,0,0,0);
    add(0,1,0,0,1,1, 5,0,0,1, 0,0,0,0);

    for (int i = 0; i < q.size(); i++) begin
      blue_crashed = q[i].blue; red_crashed = q[i].red;
      Blue_W = q[i].bw; Red_W = q[i].rw;
      s_pb = n_pb; s_pr = n_pr; s_rr = n_rr; s_mi = n_mi;
      if (q[i].start) begin
        start_key = 1'b1; step(4); start_key = 1'b0; step(4);
      end else if (q[i].frame) begin
        frame_clk = 1'b1; step(4); frame_clk = 1'b0; step(4);
      end else begin
        step(8);
      end
      $display("vec%0d: state=%0d frames_left=%0d active=%0d winner=%0d pb=%0d pr=%0d rr=%0d",
               i, Game_State, frames_left, round_active, winner,
               n_pb - s_pb, n_pr - s_pr, n_rr - s_rr);
      check("state", i, Game_State, q[i].st);
      check("frames_left", i, frames_left, q[i].fl);
      check("round_active", i, round_active, q[i].act);
      check("winner", i, winner, q[i].win);
      check("point_blue_cycles", i, n_pb - s_pb, q[i].pb);
      check("point_red_cycles", i, n_pr - s_pr, q[i].pr);
      check("reset_round_cycles", i, n_rr - s_rr, q[i].rr);
      check("match_init_cycles", i, n_mi - s_mi, q[i].mi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
Name: game_state_fsm

Overview:
- Top-level match sequencer for the two-player light-cycle game; sits directly upstream of the score block.
- Drives Game_State (value 1 clears scores) and reset_round, and converts raw crash levels from the collision detectors into single-cycle point pulses.
- Reads back Blue_W/Red_W to end the match.
- Paces countdown and pauses on the ~60 Hz frame clock.

Parameters:
- COUNTDOWN_FRAMES, 180, frame ticks spent in COUNTDOWN before each round (legal 1..255).
- PAUSE_FRAMES, 120, frame ticks spent in ROUND_OVER after a crash (legal 1..255).

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  ~60 Hz frame clock, sampled as data
- start_key  in  1  start/restart key level, asynchronous
- blue_crashed  in  1  level: blue bike hit wall or trail this frame
- red_crashed  in  1  level: red bike hit wall or trail this frame
- Blue_W  in  1  blue has won (from score)
- Red_W  in  1  red has won (from score)
- Game_State  out  3  current state encoding
- reset_round  out  1  one-cycle pulse: reposition bikes, clear trails
- point_blue  out  1  one-cycle pulse: credit blue (red crashed)
- point_red  out  1  one-cycle pulse: credit red (blue crashed)
- round_active  out  1  high only in PLAYING
- frames_left  out  8  remaining ticks in COUNTDOWN/ROUND_OVER, else 0
- winner  out  2  00 none, 01 blue, 10 red

Behaviour:
- Reset asserted: state TITLE, all outputs 0, counter 0, sync flops 0. Takes effect immediately, mid-operation included.
- Input conditioning:
  - frame_clk and start_key each pass through a 2-flop synchronizer plus rising-edge detector, giving frame_tick and start_edge (one Clk cycle each).
  - A held start_key produces exactly one start_edge.
- State encoding: TITLE=0, MATCH_INIT=1, COUNTDOWN=2, PLAYING=3, ROUND_OVER=4, MATCH_OVER=5. Codes 6 and 7 recover to TITLE on the next cycle.
- TITLE: start_edge -> MATCH_INIT.
- MATCH_INIT: occupied exactly 1 cycle.
  - Game_State=1 (score clears). reset_round=1 this cycle. winner cleared to 00.
  - Next state COUNTDOWN; counter loaded with COUNTDOWN_FRAMES.
- COUNTDOWN:
  - Each frame_tick decrements the counter.
  - A tick with counter==1 sets counter 0 and enters PLAYING on the next edge.
  - Crash inputs are ignored.
- PLAYING:
  - red_crashed only -> point_blue=1 for that cycle.
  - blue_crashed only -> point_red=1 for that cycle.
  - Both in the same cycle -> draw, no point pulse.
  - Any crash -> ROUND_OVER, counter loaded with PAUSE_FRAMES.
  - At most one point pulse per round; crash levels that persist afterwards are ignored.
- ROUND_OVER:
  - Decrements on frame_tick.
  - On the tick with counter==1, evaluate Blue_W/Red_W (the score has settled by then, since at least 1 cycle has passed since the pulse):
    - Blue_W -> MATCH_OVER, winner=01.
    - Else Red_W -> MATCH_OVER, winner=10.
    - Else -> COUNTDOWN, reset_round=1 that cycle, counter reloaded with COUNTDOWN_FRAMES.
  - Blue_W has priority if both are high.
- MATCH_OVER:
  - winner held, frames_left=0.
  - start_edge -> MATCH_INIT. start_edge in any other state except TITLE is ignored.
- Simultaneous frame_tick and crash in PLAYING: the crash is handled and the tick is dropped.
- All outputs are registered; Game_State reflects the current state with no combinational path from inputs.
- Counter is 8-bit; no wrap, because decrement occurs only when counter>=1.

Test Plan:
- COUNTDOWN_FRAMES=3, PAUSE_FRAMES=2. Assert Reset mid-COUNTDOWN -> Game_State=0 immediately, all outputs 0; release and remain in TITLE with no start.
- Press start_key for 100 cycles -> exactly one MATCH_INIT cycle (Game_State=1, reset_round=1), then COUNTDOWN with frames_left 3,2,1; PLAYING entered after the 3rd frame_tick; round_active=1.
- In PLAYING, hold red_crashed high for 50 cycles -> point_blue high exactly 1 cycle, point_red never; ROUND_OVER; after 2 ticks reset_round pulse, back to COUNTDOWN with frames_left=3.
- blue_crashed and red_crashed rise in the same cycle -> no point pulse, ROUND_OVER, then COUNTDOWN.
- Drive Blue_W=1 before the pause expires -> on the 2nd tick enter MATCH_OVER, winner=01, no reset_round; Red_W=1 alone gives winner=10; both high gives winner=01.
- In MATCH_OVER, press start -> MATCH_INIT, winner=00, Game_State=1 for one cycle. A start press during PLAYING causes no state change.
